// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, CTRL bit positions and helpers for the MMIO UART page
package mmio_pkg;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_RXDATA  = 8'h04;
    localparam logic [7:0] OFF_TXDATA  = 8'h08;
    localparam logic [7:0] OFF_CYC_LO  = 8'h10;
    localparam logic [7:0] OFF_INS_LO  = 8'h14;
    localparam logic [7:0] OFF_RST_CNT = 8'h18;
    localparam logic [7:0] OFF_CLR_OVF = 8'h1C;
    localparam logic [7:0] OFF_CYC_HI  = 8'h20;
    localparam logic [7:0] OFF_INS_HI  = 8'h24;

    localparam int CTRL_TX_NFULL   = 0;
    localparam int CTRL_RX_NEMPTY  = 1;
    localparam int CTRL_RX_OVF     = 2;
    localparam int CTRL_TX_CNT_LSB = 8;
    localparam int CTRL_RX_CNT_LSB = 16;

    // FIFO occupancy as an 8-bit CTRL field, clamped at 255.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// rtl/mmio_sync_fifo.sv - synchronous FIFO with extra-MSB pointers
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; dropped when full unless a pop happens too
//   pop, dout  : read request; dout is the head entry, 0 when empty
//   full, empty, count : occupancy status, count reaches DEPTH exactly
module mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit: equal low bits with differing MSB means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO page with buffered UART, counters and 64-bit snapshot
//   clk, rst                  : clock, synchronous active-high reset
//   en, we, addr, din, dout   : CPU data port; addr[7:0] decoded, dout combinational
//   instruction_complete      : one pulse per retired instruction
//   tx_data/tx_valid/tx_ready : byte stream to the serialiser
//   rx_data/rx_valid/rx_ready : byte stream from the deserialiser
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic                  instruction_complete,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    // Counters are held as 64 bits; in 32-bit mode the upper half is kept at 0.
    localparam logic [63:0] CNT_MASK = (CNT_WIDTH == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;

    logic [7:0]    off;
    logic          rd_cycle;
    logic          any_we;
    logic          tx_push, tx_pop, rx_pop;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [PW-1:0] tx_count, rx_count;
    logic [7:0]    rx_head;
    logic          rx_overflow;
    logic [63:0]   cycle_cnt, instr_cnt;
    logic [31:0]   cyc_snap, ins_snap;
    logic [31:0]   ctrl;
    logic          unused_bits;

    assign off         = addr[7:0];
    assign unused_bits = ^{addr[ADDR_WIDTH-1:8], din[31:8]};
    assign rd_cycle    = en & (we == 4'b0000);
    assign any_we      = en & (we != 4'b0000);
    assign tx_push     = en & we[0] & (off == OFF_TXDATA);
    assign rx_pop      = rd_cycle & (off == OFF_RXDATA);
    assign tx_pop      = tx_ready & ~tx_empty;

    mmio_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (din[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // rx_valid goes straight to push: the FIFO itself accepts a byte into a full
    // buffer when the CPU pops in the same cycle.
    mmio_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign tx_valid = ~rst & ~tx_empty;
    assign rx_ready = rst | ~rx_full;

    // A byte dropped in the same cycle as CLR_OVF keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overflow <= 1'b0;
        end else if (rx_valid & rx_full & ~rx_pop) begin
            rx_overflow <= 1'b1;
        end else if (any_we & (off == OFF_CLR_OVF)) begin
            rx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (any_we && off == OFF_RST_CNT)) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= (cycle_cnt + 64'd1) & CNT_MASK;
            if (instruction_complete) instr_cnt <= (instr_cnt + 64'd1) & CNT_MASK;
        end
    end

    // The LO read sees the pre-increment count, so latching the upper half at the
    // same edge gives a coherent 64-bit pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_snap <= '0;
            ins_snap <= '0;
        end else begin
            if (rd_cycle && off == OFF_CYC_LO) cyc_snap <= cycle_cnt[63:32];
            if (rd_cycle && off == OFF_INS_LO) ins_snap <= instr_cnt[63:32];
        end
    end

    always_comb begin
        ctrl = '0;
        ctrl[CTRL_TX_NFULL]              = ~tx_full;
        ctrl[CTRL_RX_NEMPTY]             = ~rx_empty;
        ctrl[CTRL_RX_OVF]                = rx_overflow;
        ctrl[CTRL_TX_CNT_LSB +: 8]       = sat8(32'(tx_count));
        ctrl[CTRL_RX_CNT_LSB +: 8]       = sat8(32'(rx_count));
    end

    always_comb begin
        dout = '0;
        if (en) begin
            case (off)
                OFF_CTRL:   dout = ctrl;
                OFF_RXDATA: dout = {24'h0, rx_head};
                OFF_CYC_LO: dout = cycle_cnt[31:0];
                OFF_INS_LO: dout = instr_cnt[31:0];
                OFF_CYC_HI: dout = (CNT_WIDTH == 64) ? cyc_snap : 32'h0;
                OFF_INS_HI: dout = (CNT_WIDTH == 64) ? ins_snap : 32'h0;
                default:    dout = '0;
            endcase
        end
    end

endmodule
